// File: rtl/alu_pkg.sv
// ALU operation encodings shared by the datapath ALU and the control FSM.
package alu_pkg;
    typedef enum logic [5:0] {
        ALU_ADD   = 6'd0,
        ALU_SUB   = 6'd1,
        ALU_SLL   = 6'd2,
        ALU_SLT   = 6'd3,
        ALU_SLTU  = 6'd4,
        ALU_XOR   = 6'd5,
        ALU_SRL   = 6'd6,
        ALU_SRA   = 6'd7,
        ALU_OR    = 6'd8,
        ALU_AND   = 6'd9,
        ALU_EQ    = 6'd10,
        ALU_NE    = 6'd11,
        ALU_LT    = 6'd12,
        ALU_GE    = 6'd13,
        ALU_LTU   = 6'd14,
        ALU_GEU   = 6'd15,
        ALU_PASSB = 6'd16
    } alu_sel_t;
endpackage

// File: rtl/ctrl_pkg.sv
// Control-FSM types: states, instruction classes, RV32I opcodes and mux encodings.
package ctrl_pkg;
    typedef enum logic [3:0] {
        RST_S, FETCH, IWAIT, DECODE, EXEC, MEM, DWAIT, WB, TRAP
    } ctrl_state_t;

    typedef enum logic [2:0] {
        CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR, CL_FENCE
    } instr_cls_t;

    typedef struct packed {
        alu_pkg::alu_sel_t alu_sel;
        instr_cls_t        cls;
        logic              src_a;
        logic              src_b;
    } dec_t;

    localparam dec_t DEC_NOP = '{alu_sel: alu_pkg::ALU_ADD, cls: CL_ALU, src_a: 1'b0, src_b: 1'b0};

    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] MISC_MEM = 7'b0001111;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;
endpackage

// File: rtl/instr_dec.sv
// Combinational RV32I decode: ALU op, operand sources, instruction class, illegal flag.
module instr_dec
    import alu_pkg::*;
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output dec_t       dec,
    output logic       illegal
);
    // alt is instr[30]: selects SUB/SRA over ADD/SRL
    function automatic alu_sel_t arith(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        dec     = DEC_NOP;
        illegal = 1'b0;
        case (opcode)
            OP: begin
                dec.alu_sel = arith(funct3, funct7[5]);
                illegal     = (funct7 != 7'h00) && (funct7 != 7'h20);
            end
            OP_IMM: begin
                dec.alu_sel = arith(funct3, (funct3 == 3'd5) && funct7[5]);
                dec.src_b   = 1'b1;
            end
            LUI: begin
                dec.alu_sel = ALU_PASSB;
                dec.src_b   = 1'b1;
            end
            AUIPC: begin
                dec.src_a = 1'b1;
                dec.src_b = 1'b1;
            end
            LOAD: begin
                dec.cls   = CL_LOAD;
                dec.src_b = 1'b1;
            end
            STORE: begin
                dec.cls   = CL_STORE;
                dec.src_b = 1'b1;
            end
            BRANCH: begin
                dec.cls = CL_BRANCH;
                case (funct3)
                    3'd1:    dec.alu_sel = ALU_NE;
                    3'd4:    dec.alu_sel = ALU_LT;
                    3'd5:    dec.alu_sel = ALU_GE;
                    3'd6:    dec.alu_sel = ALU_LTU;
                    3'd7:    dec.alu_sel = ALU_GEU;
                    default: dec.alu_sel = ALU_EQ;
                endcase
            end
            JAL: begin
                dec.cls   = CL_JAL;
                dec.src_a = 1'b1;
                dec.src_b = 1'b1;
            end
            JALR: begin
                dec.cls   = CL_JALR;
                dec.src_b = 1'b1;
            end
            MISC_MEM: dec.cls = CL_FENCE;
            default:  illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback over a
// shared datapath and one memory port, with illegal-instruction and bus-timeout traps.
module mc_ctrl
    import alu_pkg::*;
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        alu_res0,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output alu_sel_t    alu_sel,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic        bus_err
);
    ctrl_state_t     state_q, state_d;
    dec_t            dec_q, dec_d, dec_c;
    logic            rd_zero_q, rd_zero_d;
    logic            illegal_q, illegal_d;
    logic            bus_err_q, bus_err_d;
    logic [TO_W-1:0] to_q, to_d, to_inc;
    logic            dec_ill, waiting, timeout;
    logic            unused_rs;

    assign unused_rs = ^instr[24:15];

    instr_dec u_dec (
        .opcode (instr[6:0]),
        .funct3 (instr[14:12]),
        .funct7 (instr[31:25]),
        .dec    (dec_c),
        .illegal(dec_ill)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RST_S;
            dec_q     <= DEC_NOP;
            rd_zero_q <= 1'b1;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            dec_q     <= dec_d;
            rd_zero_q <= rd_zero_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            to_q      <= to_d;
        end
    end

    // to_inc counts the current cycle, so the trap fires after exactly TIMEOUT wait cycles
    always_comb begin
        state_d      = state_q;
        dec_d        = dec_q;
        rd_zero_d    = rd_zero_q;
        illegal_d    = illegal_q;
        bus_err_d    = bus_err_q;
        to_inc       = to_q + TO_W'(1);
        waiting      = (state_q == FETCH) || (state_q == IWAIT) ||
                       (state_q == MEM)   || (state_q == DWAIT);
        timeout      = (TIMEOUT != 0) && waiting && (to_inc == TO_W'(TIMEOUT));
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_PLUS4;
        alu_sel      = ALU_ADD;
        alu_src_a    = 1'b0;
        alu_src_b    = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = WB_ALU;

        case (state_q)
            RST_S: state_d = FETCH;
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready)    state_d = IWAIT;
                else if (timeout) state_d = TRAP;
            end
            IWAIT: begin
                ir_we = mem_rvalid;
                if (mem_rvalid)   state_d = DECODE;
                else if (timeout) state_d = TRAP;
            end
            DECODE: begin
                dec_d     = dec_c;
                rd_zero_d = (instr[11:7] == 5'd0);
                if (dec_ill) begin
                    state_d   = TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_sel   = dec_q.alu_sel;
                alu_src_a = dec_q.src_a;
                alu_src_b = dec_q.src_b;
                case (dec_q.cls)
                    CL_LOAD, CL_STORE: state_d = MEM;
                    CL_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_sel  = alu_res0 ? PC_IMM : PC_PLUS4;
                        state_d = FETCH;
                    end
                    CL_FENCE: begin
                        pc_we   = 1'b1;
                        state_d = FETCH;
                    end
                    default: state_d = WB;
                endcase
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (dec_q.cls == CL_STORE);
                if (mem_ready) begin
                    pc_we   = mem_we;
                    state_d = mem_we ? FETCH : DWAIT;
                end else if (timeout) begin
                    state_d = TRAP;
                end
            end
            DWAIT: begin
                if (mem_rvalid)   state_d = WB;
                else if (timeout) state_d = TRAP;
            end
            WB: begin
                rf_we = !rd_zero_q;
                pc_we = 1'b1;
                case (dec_q.cls)
                    CL_LOAD: wb_sel = WB_LOAD;
                    CL_JAL: begin
                        wb_sel = WB_PC4;
                        pc_sel = PC_IMM;
                    end
                    CL_JALR: begin
                        wb_sel = WB_PC4;
                        pc_sel = PC_ALU;
                    end
                    default: wb_sel = WB_ALU;
                endcase
                state_d = FETCH;
            end
            TRAP:    state_d = TRAP;
            default: state_d = RST_S;
        endcase

        // a handshake in the timeout cycle already moved the state, so only a stall traps
        if (timeout && (state_d == TRAP)) bus_err_d = 1'b1;
        to_d = (waiting && (state_d == state_q)) ? to_inc : '0;
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: expected per-cycle output vectors are queued with
// each instruction and popped against the DUT while a small memory responder drives the port.
module tb_mc_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        alu_res0 = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic        ir_we, pc_we, alu_src_a, alu_src_b, mem_req, mem_we, mem_addr_sel, rf_we;
    logic        illegal, bus_err;
    logic [1:0]  pc_sel, wb_sel;
    logic [5:0]  alu_sel;
    logic [19:0] obs;

    int n_cmp = 0;
    int n_bad = 0;
    logic [19:0] sb[$];

    // responder knobs: ready delay in MEM, extra rvalid delay for instruction fetch
    int mem_dly = 0;
    int if_rv_dly = 0;
    int wcnt = 0;
    int rv_wait = 0;
    bit rv_pend = 1'b0;

    always #5 clk = ~clk;

    mc_ctrl #(.TIMEOUT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .alu_res0    (alu_res0),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .alu_sel     (alu_sel),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr_sel(mem_addr_sel),
        .rf_we       (rf_we),
        .wb_sel      (wb_sel),
        .illegal     (illegal),
        .bus_err     (bus_err)
    );

    assign obs = {ir_we, pc_we, pc_sel, alu_sel, alu_src_a, alu_src_b,
                  mem_req, mem_we, mem_addr_sel, rf_we, wb_sel, illegal, bus_err};

    function automatic logic [19:0] ov(input logic ir, input logic pcw, input logic [1:0] pcs,
                                       input logic [5:0] alu, input logic a, input logic b,
                                       input logic req, input logic we, input logic as_,
                                       input logic rf, input logic [1:0] wb,
                                       input logic il, input logic be);
        return {ir, pcw, pcs, alu, a, b, req, we, as_, rf, wb, il, be};
    endfunction

    task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [19:0] v);
        sb.push_back(v);
    endtask

    task automatic push_front_end();
        push(ov(0,0,0,0,0,0,1,0,0,0,0,0,0));   // FETCH
        push(ov(1,0,0,0,0,0,0,0,0,0,0,0,0));   // IWAIT, rvalid
        push(20'h0);                           // DECODE
    endtask

    task automatic push_exec(input logic [5:0] alu, input logic a, input logic b,
                             input logic pcw, input logic [1:0] pcs);
        push(ov(0,pcw,pcs,alu,a,b,0,0,0,0,0,0,0));
    endtask

    task automatic push_wb(input logic [1:0] wb, input logic [1:0] pcs);
        push(ov(0,1,pcs,0,0,0,0,0,0,1,wb,0,0));
    endtask

    // one cycle: drive responder at negedge from the Moore outputs, then compare
    task automatic step(input string tag, input int idx);
        logic [19:0] e;
        @(negedge clk);
        mem_rvalid = 1'b0;
        if (rv_pend) begin
            if (rv_wait == 0) begin
                mem_rvalid = 1'b1;
                rv_pend    = 1'b0;
            end else begin
                rv_wait--;
            end
        end
        mem_ready = 1'b0;
        if (mem_req) begin
            if (wcnt >= (mem_addr_sel ? mem_dly : 0)) begin
                mem_ready = 1'b1;
                wcnt      = 0;
                if (!mem_we) begin
                    rv_pend = 1'b1;
                    rv_wait = mem_addr_sel ? 0 : if_rv_dly;
                end
            end else begin
                wcnt++;
            end
        end
        #1;
        e = sb.pop_front();
        chk($sformatf("%s[%0d]", tag, idx), obs, e);
    endtask

    task automatic run(input string tag);
        int idx = 0;
        while (sb.size() > 0) begin
            step(tag, idx);
            idx++;
        end
    endtask

    task automatic do_reset(input string tag);
        rst        = 1'b1;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        rv_pend    = 1'b0;
        wcnt       = 0;
        repeat (2) @(negedge clk);
        #1 chk({tag, "_hold"}, obs, 20'h0);
        rst = 1'b0;
        #1 chk({tag, "_rst_s"}, obs, 20'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3 chk("reset_async", obs, 20'h0);
        do_reset("reset");

        // add x3,x1,x2
        instr = 32'h002081B3;
        push_front_end();
        push_exec(ALU_ADD, 0, 0, 0, 0);
        push_wb(2'd0, 2'd0);
        run("add");

        // lw x5,4(x1), memory stalls 3 cycles
        instr = 32'h0040A283; mem_dly = 3;
        push_front_end();
        push_exec(ALU_ADD, 0, 1, 0, 0);
        repeat (4) push(ov(0,0,0,0,0,0,1,0,1,0,0,0,0));
        push(20'h0);
        push_wb(2'd1, 2'd0);
        run("lw");
        mem_dly = 0;

        // sw x2,8(x1)
        instr = 32'h0020A423;
        push_front_end();
        push_exec(ALU_ADD, 0, 1, 0, 0);
        push(ov(0,1,0,0,0,0,1,1,1,0,0,0,0));
        run("sw");

        // beq x1,x2,+8 taken then not taken
        instr = 32'h00208463; alu_res0 = 1'b1;
        push_front_end();
        push_exec(ALU_EQ, 0, 0, 1, 2'd1);
        run("beq_t");
        alu_res0 = 1'b0;
        push_front_end();
        push_exec(ALU_EQ, 0, 0, 1, 2'd0);
        run("beq_nt");

        // fence
        instr = 32'h0000000F;
        push_front_end();
        push_exec(ALU_ADD, 0, 0, 1, 2'd0);
        run("fence");

        // jalr x1,0(x5)
        instr = 32'h000280E7;
        push_front_end();
        push_exec(ALU_ADD, 0, 1, 0, 0);
        push_wb(2'd2, 2'd2);
        run("jalr");

        // rvalid lands in the very cycle the timeout would fire: handshake wins
        instr = 32'h002081B3; if_rv_dly = 7;
        push(ov(0,0,0,0,0,0,1,0,0,0,0,0,0));
        repeat (7) push(20'h0);
        push(ov(1,0,0,0,0,0,0,0,0,0,0,0,0));
        push(20'h0);
        push_exec(ALU_ADD, 0, 0, 0, 0);
        push_wb(2'd0, 2'd0);
        run("to_edge");
        if_rv_dly = 0;

        // illegal opcode, then R-type funct7=0x01
        instr = 32'h0000007F;
        push_front_end();
        repeat (4) push(ov(0,0,0,0,0,0,0,0,0,0,0,1,0));
        run("ill_op");
        do_reset("ill_op");
        instr = 32'h022081B3;
        push_front_end();
        repeat (4) push(ov(0,0,0,0,0,0,0,0,0,0,0,1,0));
        run("ill_f7");
        do_reset("ill_f7");

        // instruction read data never returns
        instr = 32'h002081B3; if_rv_dly = 1000;
        push(ov(0,0,0,0,0,0,1,0,0,0,0,0,0));
        repeat (8) push(20'h0);
        repeat (3) push(ov(0,0,0,0,0,0,0,0,0,0,0,0,1));
        run("timeout");
        do_reset("timeout");

        // async reset in the middle of IWAIT, then a clean add
        push(ov(0,0,0,0,0,0,1,0,0,0,0,0,0));
        repeat (3) push(20'h0);
        run("iwait");
        #2 rst = 1'b1;
        #1 chk("rst_mid_iwait", obs, 20'h0);
        if_rv_dly = 0;
        do_reset("rst_mid");
        push_front_end();
        push_exec(ALU_ADD, 0, 0, 0, 0);
        push_wb(2'd0, 2'd0);
        run("add_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
